// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle; result is {remainder, quotient}, sign-fixed
// on the final cycle. Execute holds start_i until ready_o and may annul an
// in-flight divide on a pipeline flush.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    localparam logic [5:0] CNT_MAX = 6'(DATA_W);

    state_t              state;
    logic [5:0]          cnt;
    // Dividend magnitude; shifts out MSB first while quotient bits shift in
    // at the bottom, so after DATA_W steps it holds the quotient magnitude.
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dsr;
    // Partial remainder between steps is always below the divisor, so only
    // the shifted value needs the extra bit.
    logic [DATA_W-1:0]   rem;
    logic                neg1;
    logic                neg2;
    logic                sgn;

    logic [DATA_W:0]     shifted;
    logic                trial_neg;
    logic [DATA_W-1:0]   trial_diff;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Trial subtraction, operand magnitudes and final sign fixup.
    always_comb begin
        shifted    = {rem, dvd[DATA_W-1]};
        trial_neg  = shifted < {1'b0, dsr};
        // When non-negative the true difference is below the divisor, so
        // the low DATA_W bits of a modular subtract are exact.
        trial_diff = shifted[DATA_W-1:0] - dsr;
        mag1       = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2       = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quo_fix    = (sgn && (neg1 ^ neg2)) ? -dvd : dvd;
        rem_fix    = (sgn && neg1) ? -rem : rem;
    end

    // Divider FSM with registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            sgn      <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state <= ON;
                            cnt   <= '0;
                            dvd   <= mag1;
                            dsr   <= mag2;
                            rem   <= '0;
                            neg1  <= opdata1_i[DATA_W-1];
                            neg2  <= opdata2_i[DATA_W-1];
                            sgn   <= signed_div_i;
                        end
                    end
                end
                BYZERO: begin
                    state    <= END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (annul_i) begin
                        state    <= FREE;
                        cnt      <= '0;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt != CNT_MAX) begin
                        if (trial_neg) begin
                            rem <= shifted[DATA_W-1:0];
                            dvd <= {dvd[DATA_W-2:0], 1'b0};
                        end else begin
                            rem <= trial_diff;
                            dvd <= {dvd[DATA_W-2:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= END;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against a plain
// arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opa),
        .opdata2_i    (opb),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Reference: truncating division, remainder takes the dividend's sign,
    // computed in 64 bits so the -2^31/-1 case wraps naturally.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drive one request, hold start until ready, then drop it. lat counts
    // edges with the sampling edge as 1; 0 means the wait expired.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat,
                           output logic post_rdy, output logic [63:0] post_res);
        @(negedge clk);
        opa = a; opb = b; signed_div = s; start = 1'b1;
        lat = 0; res = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; res = result; break; end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        post_rdy = ready;
        post_res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL reset: ready=%b result=%h, want 0/0", ready, result);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h1234, 32'h1234, 32'd0};
        logic [31:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'd1, 32'd0, 32'd0, 32'd5};
        logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [63:0] te [8] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'd1, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                                {32'd0, 32'hFFFF_FFFF}, 64'd0, 64'd0, 64'd0};
        int          tl [8] = '{34, 34, 34, 34, 34, 2, 2, 34};
        logic [63:0] res, pres;
        logic        prdy;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_div(ta[i], tb[i], ts[i], res, lat, prdy, pres);
            checks++;
            if (lat !== tl[i]) begin
                failures++;
                $display("FAIL directed%0d latency: got %0d edges, want %0d", i, lat, tl[i]);
            end
            checks++;
            if (res !== te[i]) begin
                failures++;
                $display("FAIL directed%0d result: got %h, want %h", i, res, te[i]);
            end
            checks++;
            if (prdy !== 1'b0 || pres !== 64'd0) begin
                failures++;
                $display("FAIL directed%0d drop: ready=%b result=%h, want 0/0", i, prdy, pres);
            end
        end
    endtask

    // Back-to-back random requests, including the odd zero divisor.
    task automatic test_random();
        logic [63:0] res, pres, exp;
        logic        prdy, s;
        logic [31:0] a, b;
        int          lat, exp_lat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) b = -b;
            s = 1'($urandom_range(0, 1));
            exp     = ref_div(a, b, s);
            exp_lat = (b == 32'd0) ? 2 : 34;
            run_div(a, b, s, res, lat, prdy, pres);
            checks++;
            if (res !== exp || lat !== exp_lat || prdy !== 1'b0) begin
                failures++;
                $display("FAIL random%0d %h/%h s=%b: got %h lat %0d drop %b, want %h lat %0d drop 0",
                         i, a, b, s, res, lat, prdy, exp, exp_lat);
            end
        end
    endtask

    // Abort at cnt=10 by annul (mode 0), rst (mode 1), or both (mode 2).
    task automatic test_abort();
        logic [63:0] res, pres;
        logic        prdy;
        int          lat, seen;
        for (int mode = 0; mode < 3; mode++) begin
            @(negedge clk);
            opa = $urandom; opb = 32'($urandom_range(1, 1000)); signed_div = 1'b0; start = 1'b1;
            repeat (11) @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            annul = (mode != 1);
            rst   = (mode != 0);
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0 || result !== 64'd0) begin
                failures++;
                $display("FAIL abort%0d: ready=%b result=%h, want 0/0", mode, ready, result);
            end
            @(negedge clk);
            annul = 1'b0; rst = 1'b0;
            seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready) seen++;
            end
            checks++;
            if (seen != 0) begin
                failures++;
                $display("FAIL abort%0d quiet: ready seen %0d cycles, want 0", mode, seen);
            end
            run_div(32'd9, 32'd3, 1'b0, res, lat, prdy, pres);
            checks++;
            if (res !== {32'd0, 32'd3} || lat != 34) begin
                failures++;
                $display("FAIL abort%0d follow-up: got %h lat %0d, want %h lat 34",
                         mode, res, lat, {32'd0, 32'd3});
            end
        end
    endtask

    // Operand inputs scrambled mid-divide; start held 5 extra cycles in END.
    task automatic test_operand_change();
        logic [63:0] exp;
        int          lat, bad;
        exp = ref_div(32'hFFFF_FC18, 32'd10, 1'b1);
        @(negedge clk);
        opa = 32'hFFFF_FC18; opb = 32'd10; signed_div = 1'b1; start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin opa = $urandom; opb = 32'd0; signed_div = 1'b0; end
            if (ready) begin lat = i; break; end
        end
        checks++;
        if (lat != 34 || result !== exp) begin
            failures++;
            $display("FAIL opchange: got %h lat %0d, want %h lat 34", result, lat, exp);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready !== 1'b1 || result !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold: %0d unstable cycles, want 0 (last ready=%b result=%h)",
                     bad, ready, result);
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL hold drop: ready=%b result=%h, want 0/0", ready, result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_operand_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 restoring divider serving the execute stage for DIV/DIVU.
- Execute drives the operands, signed_div_i and start_i, and stalls the pipeline until ready_o is high.
- It then writes result_o[63:32] (remainder) to HI and result_o[31:0] (quotient) to LO.
- Produces one quotient bit per cycle and supports annulment on pipeline flush.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; iteration count equals DATA_W.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset (sampled on clk rising edge)
signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled in FREE with start_i
opdata1_i  input  DATA_W  dividend; sampled in FREE with start_i
opdata2_i  input  DATA_W  divisor; sampled in FREE with start_i
start_i  input  1  request; held high by execute until ready_o is seen, then dropped
annul_i  input  1  abort in-flight or pending divide (flush)
result_o  output  2*DATA_W  {remainder, quotient}; registered
ready_o  output  1  result valid; registered

Behaviour:
- Reset: state FREE, cnt=0, result_o=0, ready_o=0. Applies regardless of state, including mid-divide.
- States: FREE, BYZERO, ON, END. Counter cnt is 6 bits wide.
- FREE:
  - start_i=1, annul_i=0, divisor=0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON with cnt=0.
    - Latch |opdata1_i| and |opdata2_i|: two's-complement magnitude when signed_div_i=1 and bit[DATA_W-1]=1; otherwise raw.
    - Latch the sign flags and signed_div_i.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge -> END with result_o=0 and ready_o=1. Annul is ignored here; END handles the exit.
- ON, annul_i=1: -> FREE, ready_o=0, result_o=0, cnt=0.
- ON, cnt<DATA_W, each cycle:
  - Partial remainder R (DATA_W+1 bits) shifted left, taking the next dividend bit MSB first.
  - Trial subtract of the divisor magnitude.
  - If the difference is negative: keep R and shift in quotient bit 0. Otherwise: R=difference and shift in quotient bit 1.
  - cnt++.
- ON, cnt==DATA_W: apply the sign fixup and go to END.
  - When signed, the quotient is negated iff the operand signs differ.
  - When signed, the remainder is negated iff the dividend was negative.
  - Set result_o={rem,quo} and ready_o=1.
- END:
  - start_i=0 -> FREE, ready_o=0, result_o=0.
  - start_i=1 -> hold result_o and ready_o; annul_i is ignored in END.
- Latency, with start_i first sampled at edge E0:
  - Nonzero divisor: ready_o rises after edge E(DATA_W+1), i.e. E33.
  - Zero divisor: ready_o rises after E1.
  - Execute drops start_i in the cycle ready_o=1, so ready_o falls after the following edge.
  - Back-to-back divides: a new start is accepted one cycle after returning to FREE.
- Operands: changes to the operand inputs while in ON/END have no effect; the latched copies are used.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF wraps. Quotient 0x80000000, remainder 0; no exception.
- rst and annul_i high in the same cycle: rst wins (same end state).

Test Plan:
- Unsigned 100/7 (start held until ready):
  - ready_o=1 exactly after the 34th edge counting E0 as the 1st.
  - result_o={32'd2, 32'd14}.
  - ready_o=0 one edge after start_i drops.
- Signed -7/2: result {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 7/-2: result {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000/0xFFFFFFFF: result {0, 0x80000000}.
- Unsigned 0xFFFFFFFF/1: result {0, 0xFFFFFFFF}.
- Divide by zero (signed and unsigned, dividend 0x1234): ready_o=1 after the 2nd edge; result_o=0.
- Abort mid-divide:
  - annul_i pulsed at cnt=10 -> FREE next edge; ready_o never asserts.
  - A following 9/3 request yields {0, 3} with full latency.
  - Repeat with rst instead of annul_i: all outputs 0 the next edge.
- Operand change while in ON: change opdata1_i/opdata2_i mid-divide, and hold start_i in END for 5 extra cycles.
  - The result still reflects the latched operands.
  - result_o and ready_o stay stable through the held cycles.
